// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle RV32I datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// with memory ready handshakes, halt on SYSTEM or an illegal opcode, and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int CNT_WIDTH       = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 pc_wr_ena,
  output logic                 ir_wr_ena,
  output logic                 reg_wr_ena,
  output logic                 dmem_rd_ena,
  output logic                 dmem_wr_ena,
  output logic                 alu_src_a_sel,
  output logic [1:0]           alu_src_b_sel,
  output logic                 alu_override,
  output logic                 reg_wr_src_sel,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_BAD       = 3'd7
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t cur, nxt;
  logic   is_op, is_load, is_store, is_lui, is_system, is_legal;
  logic   retire, set_illegal;
  logic   ir_n, reg_n, rd_n, wr_n, a_n, ovr_n, src_n, halt_n;
  logic [1:0] b_n;

  // funct3 only selects load/store width in the datapath
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign is_op     = (opcode == OPC_OP);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_legal  = is_op | is_load | is_store | is_lui | is_system | (opcode == OPC_OP_IMM);

  always_comb begin
    nxt         = cur;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (cur)
      S_IDLE:    if (run) nxt = S_FETCH;
      S_FETCH:   if (imem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (is_system) begin
          nxt = S_HALT;
        end else if (!is_legal) begin
          if (HALT_ON_ILLEGAL) begin
            nxt         = S_HALT;
            set_illegal = 1'b1;
          end else begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
        end else begin
          nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: nxt = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ready) begin
          nxt    = is_load ? S_WRITEBACK : S_FETCH;
          retire = !is_load;
        end
      end
      S_WRITEBACK: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state; the IR is already stable when
  // entering EXECUTE/MEMORY/WRITEBACK, so the current opcode is the right one.
  always_comb begin
    ir_n   = 1'b0;
    reg_n  = 1'b0;
    rd_n   = 1'b0;
    wr_n   = 1'b0;
    a_n    = 1'b0;
    b_n    = 2'b00;
    ovr_n  = 1'b0;
    src_n  = 1'b0;
    halt_n = 1'b0;
    case (nxt)
      S_FETCH: begin
        ir_n  = 1'b1;
        b_n   = 2'b01;
        ovr_n = 1'b1;
      end
      S_EXECUTE: begin
        a_n   = 1'b1;
        b_n   = is_op ? 2'b00 : 2'b10;
        ovr_n = is_load | is_store | is_lui;
      end
      S_MEMORY: begin
        rd_n = is_load;
        wr_n = is_store;
      end
      S_WRITEBACK: begin
        reg_n = 1'b1;
        src_n = !is_load;
      end
      S_HALT:  halt_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cur            <= S_IDLE;
      ir_wr_ena      <= 1'b0;
      reg_wr_ena     <= 1'b0;
      dmem_rd_ena    <= 1'b0;
      dmem_wr_ena    <= 1'b0;
      alu_src_a_sel  <= 1'b0;
      alu_src_b_sel  <= 2'b00;
      alu_override   <= 1'b0;
      reg_wr_src_sel <= 1'b0;
      halted         <= 1'b0;
      illegal_instr  <= 1'b0;
      retired_count  <= '0;
    end else begin
      cur            <= nxt;
      ir_wr_ena      <= ir_n;
      reg_wr_ena     <= reg_n;
      dmem_rd_ena    <= rd_n;
      dmem_wr_ena    <= wr_n;
      alu_src_a_sel  <= a_n;
      alu_src_b_sel  <= b_n;
      alu_override   <= ovr_n;
      reg_wr_src_sel <= src_n;
      halted         <= halt_n;
      if (set_illegal) illegal_instr <= 1'b1;
      if (retire) retired_count <= retired_count + CNT_ONE;
    end
  end

  // PC+4 is written in the same cycle the instruction word arrives
  assign pc_wr_ena = (cur == S_FETCH) && imem_ready;
  assign state     = cur;

endmodule
